// File: rtl/inst_fetch_buf.sv
// Two-entry instruction fetch buffer: a demand word (CUR) plus one sequentially
// prefetched word (PF), refilled through a single-outstanding memory read port.
module inst_fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  input  logic        flush_i,
  output logic [31:0] data_o,
  output logic        stall_req_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {StIdle, StDemand, StPrefetch} state_e;

  state_e      state_q, state_d;
  logic        cur_valid_q, cur_valid_d;
  logic [29:0] cur_addr_q, cur_addr_d;
  logic [31:0] cur_data_q, cur_data_d;
  logic        pf_valid_q, pf_valid_d;
  logic [29:0] pf_addr_q, pf_addr_d;
  logic [31:0] pf_data_q, pf_data_d;
  logic        mem_req_q, mem_req_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic        discard_q, discard_d;

  logic [29:0] word;
  logic        cur_hit, pf_hit, miss, ack_write;
  logic        unused_addr_bits;

  assign word             = addr_i[31:2];
  assign unused_addr_bits = ^addr_i[1:0];

  // A PF hit is only honoured in idle so promotion never races a refill write.
  assign cur_hit   = ce_i & cur_valid_q & (cur_addr_q == word);
  assign pf_hit    = ce_i & ~cur_hit & (state_q == StIdle) & pf_valid_q & (pf_addr_q == word);
  assign miss      = ce_i & ~cur_hit & ~pf_hit;
  assign ack_write = mem_ack_i & ~flush_i & ~discard_q;

  always_comb begin
    data_o = '0;
    if (rst) begin
      if (cur_hit) begin
        data_o = cur_data_q;
      end else if (pf_hit) begin
        data_o = pf_data_q;
      end
    end
  end

  assign stall_req_o = rst & miss;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = {mem_addr_q, 2'b00};

  always_comb begin
    state_d     = state_q;
    cur_valid_d = cur_valid_q;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    discard_d   = discard_q;

    unique case (state_q)
      StIdle: begin
        if (pf_hit) begin
          cur_valid_d = 1'b1;
          cur_addr_d  = pf_addr_q;
          cur_data_d  = pf_data_q;
          pf_valid_d  = 1'b0;
        end
        if (miss) begin
          state_d    = StDemand;
          mem_req_d  = 1'b1;
          mem_addr_d = word;
        end else if (ce_i & ~flush_i & (cur_valid_q | pf_hit) & (~pf_valid_q | pf_hit)) begin
          state_d    = StPrefetch;
          mem_req_d  = 1'b1;
          mem_addr_d = (pf_hit ? pf_addr_q : cur_addr_q) + 30'd1;
        end
      end
      StDemand: begin
        if (mem_ack_i) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          if (ack_write) begin
            cur_valid_d = 1'b1;
            cur_addr_d  = mem_addr_q;
            cur_data_d  = mem_data_i;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      StPrefetch: begin
        if (mem_ack_i) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          if (ack_write) begin
            pf_valid_d = 1'b1;
            pf_addr_d  = mem_addr_q;
            pf_data_d  = mem_data_i;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      cur_valid_d = 1'b0;
      pf_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cur_valid_q <= 1'b0;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_valid_q <= cur_valid_d;
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      pf_valid_q  <= pf_valid_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      discard_q   <= discard_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf: cycle tables, directed corner sequences and a random core
// checked against a memory-content reference with protocol invariants.
module tb_inst_fetch_buf;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic [31:0] addr_i;
  logic        flush_i;
  logic [31:0] data_o;
  logic        stall_req_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  int checks = 0;
  int errors = 0;

  int lat        = 1;
  bit rand_lat   = 0;
  bit inject_ack = 0;
  int req_cnt    = 0;
  int cur_lat    = 1;

  inst_fetch_buf dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .addr_i     (addr_i),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .stall_req_o(stall_req_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hDEAD_BEEF;
  endfunction

  // Memory: ack arrives in the lat-th cycle that mem_req_o is seen high.
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
  end
  always begin
    @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
    if (inject_ack) begin
      mem_ack_i  = 1'b1;
      mem_data_i = 32'hBAD0_BAD0;
    end else if (mem_req_o) begin
      if (req_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 3)) : lat;
      req_cnt++;
      if (req_cnt >= cur_lat) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(mem_addr_o);
        req_cnt    = 0;
      end
    end else begin
      req_cnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic ce, input logic [31:0] a, input logic fl);
    @(posedge clk);
    #1;
    ce_i    = ce;
    addr_i  = a;
    flush_i = fl;
  endtask

  task automatic chk_cycle(input string tag, input logic e_stall, input logic e_req,
                           input logic [31:0] e_maddr, input logic [31:0] e_data);
    @(negedge clk);
    check({tag, "_stall"}, 64'(stall_req_o), 64'(e_stall));
    check({tag, "_data"}, 64'(data_o), 64'(e_data));
    check({tag, "_req"}, 64'(mem_req_o), 64'(e_req));
    if (e_req) check({tag, "_maddr"}, 64'(mem_addr_o), 64'(e_maddr));
  endtask

  task automatic do_reset();
    inject_ack = 1'b0;
    flush_i    = 1'b0;
    ce_i       = 1'b1;
    addr_i     = 32'h0000_0040;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 64'(stall_req_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_req", 64'(mem_req_o), 64'd0);
    check("rst_maddr", 64'(mem_addr_o), 64'd0);
    ce_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic        flush;
    logic        stall;
    logic        req;
    logic [31:0] maddr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic ce, input logic [31:0] a, input logic fl,
                              input logic st, input logic rq, input logic [31:0] ma,
                              input logic [31:0] d);
    vec_t v;
    v.ce = ce; v.addr = a; v.flush = fl; v.stall = st; v.req = rq; v.maddr = ma; v.data = d;
    return v;
  endfunction

  logic        stalled;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;
  int          stall_run;
  int          r;

  initial begin
    rst     = 1'b1;
    ce_i    = 1'b0;
    addr_i  = '0;
    flush_i = 1'b0;

    // Sequential stream, latency 1, with flush coincident with a prefetch ack at row 13.
    vecs[0]  = mk(1, 32'h00, 0, 1, 0, 32'h00, 32'h0);
    vecs[1]  = mk(1, 32'h00, 0, 1, 1, 32'h00, 32'h0);
    vecs[2]  = mk(1, 32'h00, 0, 0, 0, 32'h00, mem_word(32'h00));
    vecs[3]  = mk(1, 32'h00, 0, 0, 1, 32'h04, mem_word(32'h00));
    vecs[4]  = mk(1, 32'h04, 0, 0, 0, 32'h00, mem_word(32'h04));
    vecs[5]  = mk(1, 32'h04, 0, 0, 1, 32'h08, mem_word(32'h04));
    vecs[6]  = mk(1, 32'h08, 0, 0, 0, 32'h00, mem_word(32'h08));
    vecs[7]  = mk(1, 32'h08, 0, 0, 1, 32'h0C, mem_word(32'h08));
    vecs[8]  = mk(1, 32'h0C, 0, 0, 0, 32'h00, mem_word(32'h0C));
    vecs[9]  = mk(0, 32'h0C, 0, 0, 1, 32'h10, 32'h0);
    vecs[10] = mk(1, 32'h0E, 0, 0, 0, 32'h00, mem_word(32'h0C));
    vecs[11] = mk(0, 32'h0E, 0, 0, 0, 32'h00, 32'h0);
    vecs[12] = mk(1, 32'h13, 0, 0, 0, 32'h00, mem_word(32'h10));
    vecs[13] = mk(1, 32'h10, 1, 0, 1, 32'h14, mem_word(32'h10));
    vecs[14] = mk(1, 32'h10, 0, 1, 0, 32'h00, 32'h0);
    vecs[15] = mk(1, 32'h10, 0, 1, 1, 32'h10, 32'h0);
    vecs[16] = mk(1, 32'h10, 0, 0, 0, 32'h00, mem_word(32'h10));

    lat = 1;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].ce, vecs[i].addr, vecs[i].flush);
      chk_cycle($sformatf("row%0d", i), vecs[i].stall, vecs[i].req, vecs[i].maddr, vecs[i].data);
    end

    // Cold miss, latency 3: four stall cycles.
    lat = 3;
    do_reset();
    step(1, 32'h0, 0);
    chk_cycle("cold_c0", 1, 0, 32'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step(1, 32'h0, 0);
      chk_cycle($sformatf("cold_c%0d", k), 1, 1, 32'h0, 32'h0);
    end
    step(1, 32'h0, 0);
    chk_cycle("cold_c4", 0, 0, 32'h0, mem_word(32'h0));

    // Branch while the prefetch of 0x104 is in flight.
    do_reset();
    step(1, 32'h100, 0);
    chk_cycle("br_c0", 1, 0, 32'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step(1, 32'h100, 0);
      chk_cycle("br_dem", 1, 1, 32'h100, 32'h0);
    end
    step(1, 32'h100, 0);
    chk_cycle("br_hit", 0, 0, 32'h0, mem_word(32'h100));
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h200, 0);
      chk_cycle("br_pf", 1, 1, 32'h104, 32'h0);
    end
    step(1, 32'h200, 0);
    chk_cycle("br_idle", 1, 0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h200, 0);
      chk_cycle("br_dem2", 1, 1, 32'h200, 32'h0);
    end
    step(1, 32'h200, 0);
    chk_cycle("br_done", 0, 0, 32'h0, mem_word(32'h200));

    // Prefetch address wraps past the top of memory.
    lat = 1;
    do_reset();
    step(1, 32'hFFFF_FFFC, 0);
    chk_cycle("wrap_c0", 1, 0, 32'h0, 32'h0);
    step(1, 32'hFFFF_FFFC, 0);
    chk_cycle("wrap_c1", 1, 1, 32'hFFFF_FFFC, 32'h0);
    step(1, 32'hFFFF_FFFC, 0);
    chk_cycle("wrap_c2", 0, 0, 32'h0, mem_word(32'hFFFF_FFFC));
    step(1, 32'hFFFF_FFFC, 0);
    chk_cycle("wrap_pf", 0, 1, 32'h0, mem_word(32'hFFFF_FFFC));
    step(1, 32'h0, 0);
    chk_cycle("wrap_hit", 0, 0, 32'h0, mem_word(32'h0));

    // Asynchronous reset mid-demand, then a stray ack after release.
    lat = 20;
    do_reset();
    step(1, 32'h40, 0);
    chk_cycle("ar_c0", 1, 0, 32'h0, 32'h0);
    step(1, 32'h40, 0);
    chk_cycle("ar_c1", 1, 1, 32'h40, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("ar_req", 64'(mem_req_o), 64'd0);
    check("ar_stall", 64'(stall_req_o), 64'd0);
    check("ar_maddr", 64'(mem_addr_o), 64'd0);
    ce_i = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
    inject_ack = 1'b1;
    @(posedge clk);
    #2;
    inject_ack = 1'b0;
    @(negedge clk);
    check("ar_ackseen", 64'(mem_ack_i), 64'd1);
    check("ar_ign_req", 64'(mem_req_o), 64'd0);
    step(1, 32'h40, 0);
    chk_cycle("ar_miss", 1, 0, 32'h0, 32'h0);
    step(1, 32'h40, 0);
    chk_cycle("ar_redem", 1, 1, 32'h40, 32'h0);

    // Random core against the memory-content reference.
    rand_lat = 1;
    do_reset();
    stalled   = 1'b0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    stall_run = 0;
    addr_i    = '0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      flush_i = ($urandom_range(0, 24) == 0);
      if (!stalled) begin
        r = int'($urandom_range(0, 99));
        if (r < 10) begin
          ce_i = 1'b0;
        end else begin
          ce_i = 1'b1;
          if (r < 60) addr_i = addr_i + 32'd4;
          else if (r < 75) addr_i = addr_i;
          else if (r < 95) addr_i = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
          else addr_i = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        end
      end
      @(negedge clk);
      if (!ce_i) begin
        check("rnd_off_data", 64'(data_o), 64'd0);
        check("rnd_off_stall", 64'(stall_req_o), 64'd0);
      end else if (!stall_req_o) begin
        check("rnd_data", 64'(data_o), 64'(mem_word(addr_i)));
        stall_run = 0;
      end else begin
        stall_run++;
        check("rnd_stall_bound", 64'(stall_run <= 10), 64'd1);
      end
      if (flush_i) stall_run = 0;
      if (prev_req && !prev_ack) check("rnd_req_hold", {31'd0, mem_req_o, mem_addr_o},
                                       {31'd0, 1'b1, prev_addr});
      if (prev_ack) check("rnd_req_drop", 64'(mem_req_o), 64'd0);
      if (mem_req_o) check("rnd_align", 64'(mem_addr_o[1:0]), 64'd0);
      prev_req  = mem_req_o;
      prev_ack  = mem_ack_i;
      prev_addr = mem_addr_o;
      stalled   = ce_i & stall_req_o;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buf.md
INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low; rst==0 resets the block.
REQ-003 SHALL have port ce_i, input, 1 bit: core fetch enable.
REQ-004 SHALL have port addr_i, input, 32 bits: core instruction address.
REQ-005 SHALL have port flush_i, input, 1 bit: invalidate all buffered instructions.
REQ-006 SHALL have port data_o, output, 32 bits: instruction for addr_i, toward the core.
REQ-007 SHALL have port stall_req_o, output, 1 bit: data_o is not valid this cycle and the core holds addr_i.
REQ-008 SHALL have port mem_req_o, output, 1 bit: memory read request.
REQ-009 SHALL have port mem_addr_o, output, 32 bits: memory read address, bits [1:0] always 0.
REQ-010 SHALL have port mem_ack_i, input, 1 bit: memory read data valid, 1-cycle pulse.
REQ-011 SHALL have port mem_data_i, input, 32 bits: memory read data, sampled when mem_ack_i==1.

Function
REQ-012 SHALL hold two entries, each {valid, word-addr[31:2], data[31:0]}: CUR (last demand word) and PF (prefetched next word).
REQ-013 SHALL compare addresses on bits [31:2] only; addr_i[1:0] SHALL be ignored.
REQ-014 Hit is combinational, with zero added latency: ce_i=1 and CUR.valid and the address matches CUR -> data_o=CUR.data and stall_req_o=0.
REQ-015 PF hit: ce_i=1, no CUR hit, PF.valid and the address matches PF -> data_o=PF.data and stall_req_o=0 in the same cycle; at the next edge PF SHALL move into CUR and PF SHALL be invalidated.
REQ-016 Miss: ce_i=1 and no hit -> stall_req_o=1 and data_o=0.
REQ-017 ce_i=0 -> data_o=0, stall_req_o=0, and no demand or prefetch request is started.
REQ-018 FSM states SHALL be IDLE, DEMAND and PREFETCH.
REQ-019 IDLE->DEMAND on a miss: assert mem_req_o with mem_addr_o={addr_i[31:2],2'b00}.
REQ-020 IDLE->PREFETCH when there is no miss, ce_i=1, CUR.valid and !PF.valid (after any promotion): request CUR address +4.
REQ-021 Prefetch address arithmetic SHALL be modulo 2^32: 0xFFFFFFFC+4 = 0x00000000.
REQ-022 mem_req_o and mem_addr_o SHALL stay stable from assertion until the cycle mem_ack_i==1 inclusive; mem_req_o SHALL drop the cycle after the ack.
REQ-023 DEMAND + ack -> write CUR, go to IDLE; the hit is visible the cycle after the ack, so a miss costs (memory latency + 1) stall cycles.
REQ-024 PREFETCH + ack -> write PF, go to IDLE; a prefetch SHALL never be aborted.
REQ-025 A miss arising during PREFETCH SHALL keep stall_req_o=1 until the prefetch completes; if the returned word matches addr_i it SHALL be a PF hit in the next cycle, otherwise a DEMAND SHALL be issued.
REQ-026 mem_ack_i while in IDLE SHALL be ignored.
REQ-027 flush_i=1 SHALL clear CUR.valid and PF.valid at the edge; an outstanding transaction SHALL complete and its data SHALL be discarded.
REQ-028 flush_i and an ack in the same cycle: flush wins, and no entry becomes valid.
REQ-029 A PF hit together with a CUR write in the same cycle SHALL not occur, because a PF hit requires state IDLE.

Reset
REQ-030 rst==0 SHALL, immediately and asynchronously, force state=IDLE, CUR.valid=0, PF.valid=0, mem_req_o=0, mem_addr_o=0, data_o=0 and stall_req_o=0.
REQ-031 Reset mid-transaction SHALL abandon the request; an ack arriving after reset is released SHALL be ignored per REQ-026.

Verification
REQ-032 Cold miss: after reset, ce_i=1, addr_i=0x00000000, memory latency 3 -> mem_req_o=1 with mem_addr_o=0 until the ack; stall_req_o=1 for 4 cycles; then data_o=mem word 0.
REQ-033 Sequential stream: addr_i 0x0,0x4,0x8,0xC with latency 1 -> after the first miss, prefetches of 0x4, 0x8 and 0xC are issued and each later address hits with stall_req_o=0.
REQ-034 Branch during prefetch: prefetch of 0x104 in flight and addr_i jumps to 0x200 -> stall held until the prefetch ack, then a DEMAND for 0x200; data_o is correct afterwards.
REQ-035 Wrap: CUR=0xFFFFFFFC -> the prefetch requests mem_addr_o=0x00000000.
REQ-036 Flush coincident with an ack: flush_i=1 in the ack cycle -> the next cycle misses and a new request is issued for the same address.
REQ-037 Asynchronous reset asserted mid-DEMAND -> mem_req_o=0 with no clock edge; a late ack causes no state change.
